// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch FSM encoding, sequential PC step and default reset PC.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry buffer for an instruction fetched while decode stalls.
// Holds the instruction word and its pc+4.
module fetch_hold_buffer (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        load,
    input  logic [31:0] instr_d,
    input  logic [63:0] pc4_d,
    output logic [31:0] instr_q,
    output logic [63:0] pc4_q
);

    register_32bit #(
        .RESET_VALUE(32'h0)
    ) u_instr (
        .clk    (clk),
        .reset  (clear_n),
        .enable (load),
        .d      (instr_d),
        .q      (instr_q)
    );

    register_64bit #(
        .RESET_VALUE(64'h0)
    ) u_pc4 (
        .clk    (clk),
        .reset  (clear_n),
        .enable (load),
        .d      (pc4_d),
        .q      (pc4_q)
    );

endmodule

// File: rtl/register_32bit.sv
// 32-bit register cell with load enable.
// Active-low synchronous clear to RESET_VALUE.
module register_32bit #(
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // Clear has priority over load.
    always_ff @(posedge clk) begin
        if (!reset)
            q <= RESET_VALUE;
        else if (enable)
            q <= d;
    end

endmodule

// File: rtl/register_64bit.sv
// 64-bit register cell with load enable.
// Active-low synchronous clear to RESET_VALUE.
module register_64bit #(
    parameter logic [63:0] RESET_VALUE = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] d,
    output logic [63:0] q
);

    // Clear has priority over load.
    always_ff @(posedge clk) begin
        if (!reset)
            q <= RESET_VALUE;
        else if (enable)
            q <= d;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, talks to instruction memory and feeds IF/ID.
// Absorbs memory wait states, decode stalls and branch redirects.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = if_fetch_pkg::DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = if_fetch_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [63:0] pc_plus4_out,
    output logic        valid_out,
    output logic        ifid_enable,
    output logic [63:0] pc_out
);

    import if_fetch_pkg::*;

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [63:0] pc;
    logic [63:0] pc_d;
    logic [63:0] pc_inc;
    logic        pc_en;

    logic [63:0] pending_pc;
    logic        pend_en;

    logic        hold_load;
    logic [31:0] hold_instr;
    logic [63:0] hold_pc4;

    assign pc_inc    = pc + 64'(PC_STEP);
    assign imem_addr = pc;
    assign pc_out    = pc;

    // A redirect always writes a bubble, even over a stall.
    assign ifid_enable = ~reset | ~stall | redirect;

    register_64bit #(
        .RESET_VALUE(RESET_PC)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .enable (pc_en),
        .d      (pc_d),
        .q      (pc)
    );

    register_64bit #(
        .RESET_VALUE(64'h0)
    ) u_pending (
        .clk    (clk),
        .reset  (reset),
        .enable (pend_en),
        .d      (redirect_pc),
        .q      (pending_pc)
    );

    fetch_hold_buffer u_hold (
        .clk     (clk),
        .clear_n (reset),
        .load    (hold_load),
        .instr_d (imem_rdata),
        .pc4_d   (pc_inc),
        .instr_q (hold_instr),
        .pc4_q   (hold_pc4)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // Next-state, PC update and IF/ID-facing outputs.
    always_comb begin
        state_nxt    = state;
        pc_d         = pc;
        pc_en        = 1'b0;
        pend_en      = 1'b0;
        hold_load    = 1'b0;
        imem_req     = 1'b0;
        valid_out    = 1'b0;
        instr_out    = 32'h0;
        pc_plus4_out = 64'h0;

        unique case (state)
            FETCH: begin
                imem_req     = 1'b1;
                instr_out    = imem_rdata;
                pc_plus4_out = pc_inc;
                if (redirect) begin
                    if (imem_ready) begin
                        pc_d  = redirect_pc;
                        pc_en = 1'b1;
                    end else begin
                        // Address must stay put until the
                        // in-flight request completes.
                        pend_en   = 1'b1;
                        state_nxt = DROP;
                    end
                end else if (imem_ready) begin
                    valid_out = 1'b1;
                    pc_d      = pc_inc;
                    pc_en     = 1'b1;
                    if (stall) begin
                        hold_load = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d      = redirect_pc;
                    pc_en     = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    valid_out    = 1'b1;
                    instr_out    = hold_instr;
                    pc_plus4_out = hold_pc4;
                    if (!stall)
                        state_nxt = FETCH;
                end
            end
            DROP: begin
                imem_req = 1'b1;
                pend_en  = redirect;
                if (imem_ready) begin
                    pc_d      = redirect ? redirect_pc : pending_pc;
                    pc_en     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        if (!reset) begin
            imem_req     = 1'b0;
            valid_out    = 1'b0;
            instr_out    = 32'h0;
            pc_plus4_out = 64'h0;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a transaction-level model.
// Model tracks next fetch address, a delivery queue and a discard target.
module tb_if_fetch_unit;

    localparam logic [63:0] RPC = 64'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [63:0] pc_plus4_out;
    logic        valid_out;
    logic        ifid_enable;
    logic [63:0] pc_out;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC(RPC),
        .PC_STEP (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .pc_plus4_out (pc_plus4_out),
        .valid_out    (valid_out),
        .ifid_enable  (ifid_enable),
        .pc_out       (pc_out)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag,
                            input logic [63:0] got,
                            input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: next fetch address, undelivered words, discard target.
    logic [63:0] m_pc;
    logic [63:0] m_tgt;
    bit          m_drop;
    logic [95:0] m_buf[$];

    task automatic model_reset();
        m_pc   = RPC;
        m_tgt  = 64'h0;
        m_drop = 1'b0;
        m_buf.delete();
    endtask

    task automatic step(input logic r, input logic st, input logic rd,
                        input logic [63:0] rp, input logic rdy);
        logic        e_req;
        logic        e_val;
        logic [31:0] e_ins;
        logic [63:0] e_pc4;
        reset       = r;
        stall       = st;
        redirect    = rd;
        redirect_pc = rp;
        imem_ready  = rdy;
        #1;
        e_ins = 32'h0;
        e_pc4 = 64'h0;
        if (!r) begin
            e_req = 1'b0;
            e_val = 1'b0;
        end else if (m_buf.size() != 0) begin
            e_req = 1'b0;
            e_val = !rd;
            if (e_val) {e_ins, e_pc4} = m_buf[0];
        end else begin
            e_req = 1'b1;
            e_val = !m_drop && rdy && !rd;
            if (e_val) begin
                e_ins = mem_word(m_pc);
                e_pc4 = m_pc + 64'd4;
            end
        end
        check_eq("addr", imem_addr, m_pc);
        check_eq("pc_out", pc_out, m_pc);
        check_eq("req", 64'(imem_req), 64'(e_req));
        check_eq("valid", 64'(valid_out), 64'(e_val));
        check_eq("enable", 64'(ifid_enable), 64'(!r || !st || rd));
        if (e_val || !r) begin
            check_eq("instr", 64'(instr_out), 64'(e_ins));
            check_eq("pc4", pc_plus4_out, e_pc4);
        end
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else if (m_buf.size() != 0) begin
            if (rd) begin
                m_buf.delete();
                m_pc = rp;
            end else if (!st) begin
                void'(m_buf.pop_front());
            end
        end else if (m_drop) begin
            if (rd) m_tgt = rp;
            if (rdy) begin
                m_pc   = m_tgt;
                m_drop = 1'b0;
            end
        end else if (rd) begin
            if (rdy) begin
                m_pc = rp;
            end else begin
                m_drop = 1'b1;
                m_tgt  = rp;
            end
        end else if (rdy) begin
            if (st) m_buf.push_back({mem_word(m_pc), m_pc + 64'd4});
            m_pc = m_pc + 64'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        imem_ready  = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);

        // Sequential fetch from reset
        check_eq("t1_addr0", imem_addr, 64'h1000);
        repeat (3) step(1, 0, 0, 0, 1);
        check_eq("t1_addr3", imem_addr, 64'h100C);

        // Wait states
        step(1, 0, 1, 64'h2000, 1);
        repeat (3) step(1, 0, 0, 0, 0);
        check_eq("t2_addr", imem_addr, 64'h2000);
        step(1, 0, 0, 0, 1);

        // Stall on handshake, then release
        step(1, 0, 1, 64'h3000, 1);
        step(1, 1, 0, 0, 1);
        repeat (3) step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check_eq("t3_addr", imem_addr, 64'h3004);
        step(1, 0, 0, 0, 1);

        // Redirect during pending request
        step(1, 0, 1, 64'h4000, 1);
        step(1, 0, 1, 64'h8000, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        check_eq("t4_addr", imem_addr, 64'h8000);
        step(1, 0, 0, 0, 1);

        // Redirect plus stall in HOLD
        step(1, 0, 1, 64'h5000, 1);
        step(1, 1, 0, 0, 1);
        step(1, 1, 1, 64'h9000, 0);
        check_eq("t5_addr", imem_addr, 64'h9000);
        step(1, 0, 0, 0, 1);

        // PC wrap, then reset mid-HOLD
        step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        step(1, 0, 0, 0, 1);
        check_eq("t6_wrap", imem_addr, 64'h0);
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        check_eq("t6_rst", imem_addr, RPC);
        step(1, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [63:0] rp;
            rp = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0)
                rp = 64'hFFFF_FFFF_FFFF_FFF8;
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) == 0,
                 rp,
                 $urandom_range(0, 9) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
